// File: rtl/turf_bus_pkg.sv
// turf_bus_pkg: shared state encoding, limits and byte-parity helper for the TURF bus slave.
package turf_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WADDR = 3'd1,
        ST_WDATA = 3'd2,
        ST_RSTB  = 3'd3,
        ST_RWAIT = 3'd4,
        ST_RDATA = 3'd5
    } state_e;

    localparam int MAX_DATA_BYTES = 8;
    localparam int MAX_RD_LATENCY = 3;

    // Bit k is the even parity of byte k of the word.
    function automatic logic [7:0] byte_parity(input logic [8*MAX_DATA_BYTES-1:0] w);
        logic [7:0] p;
        for (int i = 0; i < MAX_DATA_BYTES; i++) p[i] = ^w[8*i +: 8];
        return p;
    endfunction

endpackage

// File: rtl/turf_bus_word_shift.sv
// turf_bus_word_shift: word register with parallel load, LSB-first byte shift-in and byte shift-out.
module turf_bus_word_shift #(
    parameter int DW = 32
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          load_i,
    input  logic [DW-1:0] load_data_i,
    input  logic          shift_in_i,
    input  logic [7:0]    byte_i,
    input  logic          shift_out_i,
    output logic [DW-1:0] word_o,
    output logic [7:0]    next_byte_o
);

    logic [DW-1:0] word_q;
    logic [DW+7:0] sin;
    logic [DW+7:0] sout;

    assign sin         = {byte_i, word_q};
    assign sout        = {8'h00, word_q};
    assign word_o      = word_q;
    assign next_byte_o = sout[15:8];

    always_ff @(posedge clk_i) begin
        if (!rst_n_i)         word_q <= '0;
        else if (load_i)      word_q <= load_data_i;
        else if (shift_in_i)  word_q <= sin[DW+7:8];
        else if (shift_out_i) word_q <= sout[DW+7:8];
    end

endmodule

// File: rtl/turf_bus_slave_v3.sv
// turf_bus_slave_v3: byte-serial TURFIO bus slave issuing register read/write strobes with burst and abort.
// Optional TURF_BUS_PARITY_EN adds a per-word parity byte on writes and reads plus an error counter.
module turf_bus_slave_v3 import turf_bus_pkg::*; #(
    parameter int DATA_BYTES = 4,
    parameter int ADDR_BITS  = 8,
    parameter int RD_LATENCY = 0
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    ncs_i,
    input  logic                    wnr_i,
    input  logic [7:0]              dio_i,
    output logic [7:0]              dio_o,
    output logic                    dio_oe_o,
    output logic                    wr_stb_o,
    output logic [ADDR_BITS-1:0]    wr_addr_o,
    output logic [8*DATA_BYTES-1:0] wr_data_o,
    output logic                    rd_stb_o,
    output logic [ADDR_BITS-1:0]    rd_addr_o,
    input  logic [8*DATA_BYTES-1:0] rd_data_i,
    output logic                    abort_o,
`ifdef TURF_BUS_PARITY_EN
    output logic [7:0]              parity_err_cnt_o,
`endif
    output logic [2:0]              state_o
);

    localparam int DW = 8*DATA_BYTES;
`ifdef TURF_BUS_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam logic [3:0] WR_STB   = 4'(DATA_BYTES + PB);
    localparam logic [3:0] RD_LAST  = 4'(DATA_BYTES - 1 + PB);
    localparam logic [3:0] LAT_LAST = (RD_LATENCY == 0) ? 4'd0 : 4'(RD_LATENCY - 1);

    state_e               state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [7:0]           dio_q, dio_d;
    logic                 oe_q, oe_d;
    logic                 abort_q, abort_d;
    logic                 ws_load, ws_shin, ws_shout;
    logic [DW-1:0]        ws_word;
    logic [7:0]           ws_next;
`ifdef TURF_BUS_PARITY_EN
    logic [7:0]           par_q, par_d;
    logic [7:0]           perr_q, perr_d;
`endif

    turf_bus_word_shift #(.DW(DW)) u_shift (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .load_i      (ws_load),
        .load_data_i (rd_data_i),
        .shift_in_i  (ws_shin),
        .byte_i      (dio_i),
        .shift_out_i (ws_shout),
        .word_o      (ws_word),
        .next_byte_o (ws_next)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            dio_q   <= '0;
            oe_q    <= 1'b0;
            abort_q <= 1'b0;
`ifdef TURF_BUS_PARITY_EN
            par_q   <= '0;
            perr_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            dio_q   <= dio_d;
            oe_q    <= oe_d;
            abort_q <= abort_d;
`ifdef TURF_BUS_PARITY_EN
            par_q   <= par_d;
            perr_q  <= perr_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        dio_d    = dio_q;
        oe_d     = oe_q;
        abort_d  = 1'b0;
        ws_load  = 1'b0;
        ws_shin  = 1'b0;
        ws_shout = 1'b0;
`ifdef TURF_BUS_PARITY_EN
        par_d    = par_q;
        perr_d   = perr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                oe_d  = 1'b0;
                dio_d = 8'h00;
                if (!ncs_i) begin
                    addr_d  = dio_i[ADDR_BITS-1:0];
                    cnt_d   = '0;
                    state_d = wnr_i ? ST_WDATA : ST_RSTB;
                end
            end
            ST_WDATA: begin
                // Strobe cycle: the burst decision shares it, so the strobe sees the old address.
                if (cnt_q == WR_STB) begin
                    if (!ncs_i) begin
                        addr_d = addr_q + 1'b1;
                        cnt_d  = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (ncs_i) begin
                    abort_d = 1'b1;
                    state_d = ST_IDLE;
`ifdef TURF_BUS_PARITY_EN
                end else if (cnt_q == 4'(DATA_BYTES)) begin
                    if (dio_i == byte_parity(64'(ws_word))) begin
                        cnt_d = cnt_q + 1'b1;
                    end else begin
                        abort_d = 1'b1;
                        state_d = ST_IDLE;
                        perr_d  = (perr_q == 8'hFF) ? perr_q : perr_q + 8'd1;
                    end
`endif
                end else begin
                    ws_shin = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            ST_RSTB, ST_RWAIT: begin
                if (ncs_i) begin
                    abort_d = 1'b1;
                    state_d = ST_IDLE;
                    oe_d    = 1'b0;
                    dio_d   = 8'h00;
                end else if (state_q == ST_RSTB && RD_LATENCY != 0) begin
                    state_d = ST_RWAIT;
                    cnt_d   = '0;
                end else if (state_q == ST_RWAIT && cnt_q != LAT_LAST) begin
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    ws_load = 1'b1;
                    dio_d   = rd_data_i[7:0];
                    oe_d    = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_RDATA;
`ifdef TURF_BUS_PARITY_EN
                    par_d   = byte_parity(64'(rd_data_i));
`endif
                end
            end
            ST_RDATA: begin
                if (cnt_q == RD_LAST) begin
                    dio_d = 8'h00;
                    if (!ncs_i) begin
                        addr_d  = addr_q + 1'b1;
                        state_d = ST_RSTB;
                    end else begin
                        oe_d    = 1'b0;
                        state_d = ST_IDLE;
                    end
                end else if (ncs_i) begin
                    abort_d = 1'b1;
                    state_d = ST_IDLE;
                    oe_d    = 1'b0;
                    dio_d   = 8'h00;
                end else begin
                    ws_shout = 1'b1;
                    cnt_d    = cnt_q + 1'b1;
`ifdef TURF_BUS_PARITY_EN
                    dio_d    = (cnt_q == 4'(DATA_BYTES - 1)) ? par_q : ws_next;
`else
                    dio_d    = ws_next;
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign wr_stb_o  = (state_q == ST_WDATA) && (cnt_q == WR_STB);
    assign wr_addr_o = addr_q;
    assign wr_data_o = ws_word;
    assign rd_stb_o  = (state_q == ST_RSTB);
    assign rd_addr_o = addr_q;
    assign dio_o     = dio_q;
    assign dio_oe_o  = oe_q;
    assign abort_o   = abort_q;
    assign state_o   = state_q;
`ifdef TURF_BUS_PARITY_EN
    assign parity_err_cnt_o = perr_q;
`endif

endmodule

// File: tb/tb_turf_bus_slave_v3.sv
// tb_turf_bus_slave_v3: directed checks of two slave builds (defaults, and 2-byte words with read latency 2).
module tb_turf_bus_slave_v3;

    logic        clk = 1'b0, rst_n = 1'b0, ncs_a = 1'b1, ncs_b = 1'b1, wnr = 1'b0;
    logic [7:0]  din = 8'h00;
    logic [31:0] rd_data_a = '0;
    logic [15:0] rd_data_b = '0;
    logic [7:0]  dio_a, dio_b, wr_addr_a, wr_addr_b, rd_addr_a, rd_addr_b;
    logic        oe_a, oe_b, wr_stb_a, wr_stb_b, rd_stb_a, rd_stb_b, abort_a, abort_b;
    logic [31:0] wr_data_a;
    logic [15:0] wr_data_b;
    logic [2:0]  state_a, state_b;
`ifdef TURF_BUS_PARITY_EN
    logic [7:0]  perr_a, perr_b;
`endif
    int n_chk = 0, n_err = 0, n_wstb_a = 0, n_rstb_b = 0;

    always #5 clk = ~clk;

    turf_bus_slave_v3 u_a (
        .clk_i(clk), .rst_n_i(rst_n), .ncs_i(ncs_a), .wnr_i(wnr), .dio_i(din),
        .dio_o(dio_a), .dio_oe_o(oe_a), .wr_stb_o(wr_stb_a), .wr_addr_o(wr_addr_a),
        .wr_data_o(wr_data_a), .rd_stb_o(rd_stb_a), .rd_addr_o(rd_addr_a),
        .rd_data_i(rd_data_a), .abort_o(abort_a),
`ifdef TURF_BUS_PARITY_EN
        .parity_err_cnt_o(perr_a),
`endif
        .state_o(state_a)
    );

    turf_bus_slave_v3 #(.DATA_BYTES(2), .RD_LATENCY(2)) u_b (
        .clk_i(clk), .rst_n_i(rst_n), .ncs_i(ncs_b), .wnr_i(wnr), .dio_i(din),
        .dio_o(dio_b), .dio_oe_o(oe_b), .wr_stb_o(wr_stb_b), .wr_addr_o(wr_addr_b),
        .wr_data_o(wr_data_b), .rd_stb_o(rd_stb_b), .rd_addr_o(rd_addr_b),
        .rd_data_i(rd_data_b), .abort_o(abort_b),
`ifdef TURF_BUS_PARITY_EN
        .parity_err_cnt_o(perr_b),
`endif
        .state_o(state_b)
    );

    always @(negedge clk) begin
        if (wr_stb_a) n_wstb_a++;
        if (rd_stb_b) n_rstb_b++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: no finish after 200000 time units");
        $fatal(1);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Starts in the cycle after the address byte (or after the previous strobe cycle in a burst).
    task automatic wr_word(input logic [31:0] w, input logic [7:0] ea, input logic last, input string tag);
        for (int b = 0; b < 4; b++) begin
            chk({tag, "_nostb"}, wr_stb_a, 1'b0);
            chk({tag, "_wr_oe"}, oe_a, 1'b0);
            din = w[8*b +: 8];
            cyc();
        end
        chk({tag, "_stb"}, wr_stb_a, 1'b1);
        chk({tag, "_waddr"}, wr_addr_a, ea);
        chk({tag, "_wdata"}, wr_data_a, w);
        ncs_a = last;
        cyc();
    endtask

    task automatic rd_word(input logic [31:0] w, input logic [7:0] ea, input string tag);
        chk({tag, "_rstb"}, rd_stb_a, 1'b1);
        chk({tag, "_raddr"}, rd_addr_a, ea);
        chk({tag, "_rstb_oe"}, oe_a, 1'b0);
        cyc();
        for (int b = 0; b < 4; b++) begin
            chk({tag, "_oe"}, oe_a, 1'b1);
            chk({tag, "_dio"}, dio_a, w[8*b +: 8]);
            if (b == 3) ncs_a = 1'b1;
            cyc();
        end
        chk({tag, "_oe_end"}, oe_a, 1'b0);
        chk({tag, "_idle"}, state_a, 3'd0);
    endtask

    initial begin
        repeat (3) cyc();
        chk("rst_state", state_a, 3'd0);
        chk("rst_oe", oe_a, 1'b0);
        chk("rst_dio", dio_a, 8'h00);
        chk("rst_wstb", wr_stb_a, 1'b0);
        chk("rst_rstb", rd_stb_a, 1'b0);
        chk("rst_abort", abort_a, 1'b0);
        chk("rst_wdata", wr_data_a, 32'h0);
        chk("rst_b_oe", oe_b, 1'b0);
        rst_n = 1'b1;
        cyc();

        // single write
        ncs_a = 1'b0; wnr = 1'b1; din = 8'h06; cyc();
        wr_word(32'h44332211, 8'h06, 1'b1, "w1");
        chk("w1_idle", state_a, 3'd0);
        chk("w1_noabort", abort_a, 1'b0);
        chk("w1_count", n_wstb_a, 1);

        // single read, latency 0
        rd_data_a = 32'hDEADBEEF;
        ncs_a = 1'b0; wnr = 1'b0; din = 8'h0B; cyc();
        rd_word(32'hDEADBEEF, 8'h0B, "r1");

        // burst write across the address wrap
        ncs_a = 1'b0; wnr = 1'b1; din = 8'hFF; cyc();
        wr_word(32'hCAFEF00D, 8'hFF, 1'b0, "bw0");
        wr_word(32'h12345678, 8'h00, 1'b0, "bw1");
        wr_word(32'h0BADBEEF, 8'h01, 1'b1, "bw2");
        chk("bw_count", n_wstb_a, 4);
        chk("bw_idle", state_a, 3'd0);

        // burst read on the 2-byte, latency-2 instance
        rd_data_b = 16'h1234;
        ncs_b = 1'b0; wnr = 1'b0; din = 8'h10; cyc();
        chk("b_rstb1", rd_stb_b, 1'b1);
        chk("b_raddr1", rd_addr_b, 8'h10);
        chk("b_oe_first", oe_b, 1'b0);
        cyc();
        chk("b_wait_stb", rd_stb_b, 1'b0);
        chk("b_wait_oe", oe_b, 1'b0);
        cyc();
        cyc();
        chk("b_oe0", oe_b, 1'b1);
        chk("b_byte0", dio_b, 8'h34);
        cyc();
        chk("b_byte1", dio_b, 8'h12);
        rd_data_b = 16'h5678;
        cyc();
        chk("b_rstb2", rd_stb_b, 1'b1);
        chk("b_raddr2", rd_addr_b, 8'h11);
        chk("b_rstb_cnt", n_rstb_b, 1);
        for (int i = 0; i < 3; i++) begin
            chk("b_gap_oe", oe_b, 1'b1);
            chk("b_gap_dio", dio_b, 8'h00);
            cyc();
        end
        chk("b_byte2", dio_b, 8'h78);
        cyc();
        chk("b_byte3", dio_b, 8'h56);
        ncs_b = 1'b1;
        cyc();
        chk("b_oe_end", oe_b, 1'b0);
        chk("b_idle", state_b, 3'd0);
        chk("b_rstb_total", n_rstb_b, 2);

        // truncated write
        ncs_a = 1'b0; wnr = 1'b1; din = 8'h20; cyc();
        din = 8'h01; cyc();
        din = 8'h02; cyc();
        ncs_a = 1'b1; cyc();
        chk("ab_pulse", abort_a, 1'b1);
        chk("ab_idle", state_a, 3'd0);
        cyc();
        chk("ab_pulse_end", abort_a, 1'b0);
        chk("ab_nostb", n_wstb_a, 4);
        ncs_a = 1'b0; wnr = 1'b1; din = 8'h21; cyc();
        wr_word(32'h89ABCDEF, 8'h21, 1'b1, "w2");
        chk("w2_count", n_wstb_a, 5);

        // reset in the middle of a read
        rd_data_a = 32'h01020304;
        ncs_a = 1'b0; wnr = 1'b0; din = 8'h30; cyc();
        cyc();
        chk("rr_dio0", dio_a, 8'h04);
        rst_n = 1'b0; ncs_a = 1'b1; cyc();
        chk("rr_oe", oe_a, 1'b0);
        chk("rr_state", state_a, 3'd0);
        chk("rr_dio", dio_a, 8'h00);
        rst_n = 1'b1; cyc();
        rd_data_a = 32'hCAFEBABE;
        ncs_a = 1'b0; wnr = 1'b0; din = 8'h31; cyc();
        rd_word(32'hCAFEBABE, 8'h31, "r2");

`ifdef TURF_BUS_PARITY_EN
        // bad parity byte: correct parity of 11,22,33,44 is 0x00
        ncs_a = 1'b0; wnr = 1'b1; din = 8'h40; cyc();
        din = 8'h11; cyc();
        din = 8'h22; cyc();
        din = 8'h33; cyc();
        din = 8'h44; cyc();
        din = 8'hFF; cyc();
        chk("par_abort", abort_a, 1'b1);
        chk("par_nostb", wr_stb_a, 1'b0);
        chk("par_cnt", perr_a, 8'd1);
        ncs_a = 1'b1; cyc();
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
